// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the memory controller
package mem_ctrl_pkg;

  // Depth of the posted write buffer; pointers are a single bit.
  localparam int WB_DEPTH = 2;

  // Width of the access wait counter; supports WAIT_STATES 0..7.
  localparam int WAIT_W = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WR_ACCESS = 2'd1,
    RD_ACCESS = 2'd2,
    RD_RESP   = 2'd3
  } mem_ctrl_state_t;

  // Reload value of the wait counter for a given number of extra cycles.
  function automatic logic [WAIT_W-1:0] wait_load(input int wait_states);
    return WAIT_W'(wait_states);
  endfunction

endpackage

// File: rtl/mem_wbuf.sv
// rtl/mem_wbuf.sv - two-entry posted write buffer holding {addr, data}
module mem_wbuf
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count
);

  logic [ADDR_W-1:0] addr_q [WB_DEPTH];
  logic [ADDR_W-1:0] addr_d [WB_DEPTH];
  logic [DATA_W-1:0] data_q [WB_DEPTH];
  logic [DATA_W-1:0] data_d [WB_DEPTH];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  // Full is taken from the count before any pop this cycle, so a push that
  // coincides with a pop on a full buffer is refused.
  assign full      = (count_q == 2'(WB_DEPTH));
  assign empty     = (count_q == 2'd0);
  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign count     = count_q;
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;

  // Next-state for storage, pointers (wrap 1->0 by inversion) and count.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    if (push_ok) begin
      addr_d[wr_ptr_q] = push_addr;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  // Buffer state registers; reset discards every posted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WB_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - SRAM controller with posted writes and wait-stated accesses
`ifndef MEMORY_SIZE_ENC
`define MEMORY_SIZE_ENC 7
`endif
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 8
`endif

module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = `MEMORY_SIZE_ENC + 1,
  parameter int DATA_W      = `MEMORY_WIDTH,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mrd,
  input  logic              mwr,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rvalid,
  output logic              mem_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_ce,
  output logic              ram_we,
  output logic              ram_oe
);

  localparam logic [WAIT_W-1:0] WAIT_LD = wait_load(WAIT_STATES);

  mem_ctrl_state_t   state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              wb_push;
  logic              wb_pop;
  logic              wb_full;
  logic              wb_empty;
  logic [ADDR_W-1:0] wb_head_addr;
  logic [DATA_W-1:0] wb_head_data;
  logic [1:0]        wb_count;

  logic              wr_ok;
  logic              rd_ok;
  logic              rd_accept;
  logic              access_done;

  mem_wbuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (wb_push),
    .push_addr (mem_addr),
    .push_data (mem_wdata),
    .pop       (wb_pop),
    .full      (wb_full),
    .empty     (wb_empty),
    .head_addr (wb_head_addr),
    .head_data (wb_head_data),
    .count     (wb_count)
  );

  // Request acceptance: writes post whenever there is room outside a read,
  // reads only start from an idle controller with nothing left to drain.
  // A write wins over a simultaneous read.
  always_comb begin
    wr_ok       = !wb_full && (state_q != RD_ACCESS) && (state_q != RD_RESP);
    rd_ok       = (state_q == IDLE) && wb_empty;
    wb_push     = mwr && wr_ok;
    rd_accept   = mrd && !mwr && rd_ok;
    mem_ready   = mwr ? wr_ok : (mrd && rd_ok);
    access_done = (wait_q == '0);
  end

  // Access sequencing: drain posted writes first, then serve a read.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    rd_addr_d = rd_addr_q;
    rdata_d   = rdata_q;
    wb_pop    = 1'b0;
    err_d     = err_q | (mrd & mwr);
    case (state_q)
      IDLE: begin
        if (!wb_empty) begin
          state_d = WR_ACCESS;
          wait_d  = WAIT_LD;
        end else if (rd_accept) begin
          state_d   = RD_ACCESS;
          wait_d    = WAIT_LD;
          rd_addr_d = mem_addr;
        end
      end
      WR_ACCESS: begin
        if (access_done) begin
          wb_pop = 1'b1;
          // Something remains after the pop: chain straight into it.
          if ((wb_count == 2'd2) || wb_push) begin
            wait_d = WAIT_LD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      RD_ACCESS: begin
        if (access_done) begin
          rdata_d = ram_rdata;
          state_d = RD_RESP;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      RD_RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      rd_addr_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      rd_addr_q <= rd_addr_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // SRAM strobes decode from the registered state only, so we and oe are
  // mutually exclusive and drop the moment reset clears the state.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_oe    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state_q)
      WR_ACCESS: begin
        ram_ce    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = wb_head_addr;
        ram_wdata = wb_head_data;
      end
      RD_ACCESS: begin
        ram_ce   = 1'b1;
        ram_oe   = 1'b1;
        ram_addr = rd_addr_q;
      end
      default: begin
        ram_ce = 1'b0;
      end
    endcase
  end

  assign mem_rvalid = (state_q == RD_RESP);
  assign mem_rdata  = rdata_q;
  assign mem_err    = err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mrd;
  logic       mwr;
  int         sel;
  int         tests;
  int         fails;

  logic       mem_ready_w  [2];
  logic [7:0] mem_rdata_w  [2];
  logic       mem_rvalid_w [2];
  logic       mem_err_w    [2];
  logic [7:0] ram_addr_w   [2];
  logic [7:0] ram_wdata_w  [2];
  logic [7:0] ram_rdata_w  [2];
  logic       ram_ce_w     [2];
  logic       ram_we_w     [2];
  logic       ram_oe_w     [2];

  logic       t_ready;
  logic       t_rvalid;
  logic [7:0] t_rdata;

  always #5 clk = ~clk;

  // Instance 0 runs with WAIT_STATES=2, instance 1 with WAIT_STATES=0.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       mrd_g;
    logic       mwr_g;
    bit   [7:0] ram_d [256];
    bit         ram_v [256];
    int         oe_cnt;
    int         we_cnt;
    int         rv_cnt;
    int         both_cnt;
    int         cyc;
    logic [15:0] wlog  [64];
    int          wtime [64];

    assign mrd_g = mrd && (sel == g);
    assign mwr_g = mwr && (sel == g);

    mem_ctrl #(
      .ADDR_W      (8),
      .DATA_W      (8),
      .WAIT_STATES ((g == 0) ? 2 : 0)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mrd        (mrd_g),
      .mwr        (mwr_g),
      .mem_ready  (mem_ready_w[g]),
      .mem_rdata  (mem_rdata_w[g]),
      .mem_rvalid (mem_rvalid_w[g]),
      .mem_err    (mem_err_w[g]),
      .ram_addr   (ram_addr_w[g]),
      .ram_wdata  (ram_wdata_w[g]),
      .ram_rdata  (ram_rdata_w[g]),
      .ram_ce     (ram_ce_w[g]),
      .ram_we     (ram_we_w[g]),
      .ram_oe     (ram_oe_w[g])
    );

    // SRAM model: unwritten locations read back as addr ^ 0xB5.
    assign ram_rdata_w[g] = !ram_oe_w[g] ? 8'h00 :
                            ram_v[ram_addr_w[g]] ? ram_d[ram_addr_w[g]] :
                            (ram_addr_w[g] ^ 8'hB5);

    always @(posedge clk) begin
      if (ram_ce_w[g] && ram_we_w[g]) begin
        ram_d[ram_addr_w[g]] <= ram_wdata_w[g];
        ram_v[ram_addr_w[g]] <= 1'b1;
      end
    end

    always @(negedge clk) begin
      cyc      <= cyc + 1;
      oe_cnt   <= oe_cnt + int'(ram_oe_w[g]);
      we_cnt   <= we_cnt + int'(ram_we_w[g]);
      rv_cnt   <= rv_cnt + int'(mem_rvalid_w[g]);
      both_cnt <= both_cnt + int'(ram_oe_w[g] && ram_we_w[g]);
      if (ram_we_w[g]) begin
        wlog[we_cnt % 64]  <= {ram_addr_w[g], ram_wdata_w[g]};
        wtime[we_cnt % 64] <= cyc;
      end
    end
  end

  assign t_ready  = (sel == 0) ? mem_ready_w[0]  : mem_ready_w[1];
  assign t_rvalid = (sel == 0) ? mem_rvalid_w[0] : mem_rvalid_w[1];
  assign t_rdata  = (sel == 0) ? mem_rdata_w[0]  : mem_rdata_w[1];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold a write until accepted; stall counts the cycles mem_ready was low.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d, output int stall);
    mwr = 1'b1;
    mem_addr = a;
    mem_wdata = d;
    stall = 0;
    #1;
    while (!t_ready && stall < 40) begin
      @(negedge clk);
      #1;
      stall++;
    end
    if (!t_ready) check_eq("wr_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    mwr = 1'b0;
  endtask

  // Hold a read until accepted; lat counts edges from accept to rvalid.
  task automatic do_read(input logic [7:0] a, output logic [7:0] data,
                         output int stall, output int lat);
    mrd = 1'b1;
    mem_addr = a;
    stall = 0;
    lat = 0;
    data = 8'h00;
    #1;
    while (!t_ready && stall < 40) begin
      @(negedge clk);
      #1;
      stall++;
    end
    if (!t_ready) check_eq("rd_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    mrd = 1'b0;
    lat = 1;
    while (!t_rvalid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!t_rvalid) check_eq("rvalid_timeout", 32'd0, 32'd1);
    data = t_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         s;
    int         l;
    logic [7:0] d;
    int         b_oe;
    int         b_we;
    int         b_rv;
    logic [7:0] ea;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    mrd = 1'b0;
    mwr = 1'b0;
    mem_addr = 8'h00;
    mem_wdata = 8'h00;
    sel = 0;
    idle(2);
    #1;
    check_eq("rst_ctl_ws2", 32'({mem_ready_w[0], mem_rvalid_w[0], mem_err_w[0],
                                  ram_ce_w[0], ram_we_w[0], ram_oe_w[0]}), 32'd0);
    check_eq("rst_data_ws2", 32'({mem_rdata_w[0], ram_addr_w[0], ram_wdata_w[0]}), 32'd0);
    check_eq("rst_ctl_ws0", 32'({mem_rvalid_w[1], mem_err_w[1], ram_ce_w[1],
                                  ram_we_w[1], ram_oe_w[1], mem_rdata_w[1]}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Single read from an idle controller.
    b_oe = g_dut[0].oe_cnt;
    b_rv = g_dut[0].rv_cnt;
    do_read(8'h10, d, s, l);
    check_eq("rd1_stall", 32'(s), 32'd0);
    check_eq("rd1_latency", 32'(l), 32'd4);
    check_eq("rd1_data", 32'(d), 32'hA5);
    idle(4);
    check_eq("rd1_oe_cycles", 32'(g_dut[0].oe_cnt - b_oe), 32'd3);
    check_eq("rd1_rvalid_pulses", 32'(g_dut[0].rv_cnt - b_rv), 32'd1);
    check_eq("rd1_rdata_hold", 32'(t_rdata), 32'hA5);
    check_eq("rd1_rvalid_low", 32'(t_rvalid), 32'd0);

    // Three back-to-back writes: third waits for the first pop.
    b_we = g_dut[0].we_cnt;
    do_write(8'h01, 8'h11, s);
    check_eq("wr1_stall", 32'(s), 32'd0);
    do_write(8'h02, 8'h22, s);
    check_eq("wr2_stall", 32'(s), 32'd0);
    do_write(8'h03, 8'h33, s);
    check_eq("wr3_stall", 32'(s), 32'd3);
    idle(12);
    check_eq("wr3x_we_cycles", 32'(g_dut[0].we_cnt - b_we), 32'd9);
    for (int k = 0; k < 9; k++) begin
      ea = 8'(k / 3 + 1);
      check_eq($sformatf("wr3x_ram_%0d", k),
               32'(g_dut[0].wlog[(b_we + k) % 64]), 32'({ea, 8'(ea * 8'h11)}));
      if (k > 0)
        check_eq($sformatf("wr3x_gap_%0d", k),
                 32'(g_dut[0].wtime[(b_we + k) % 64] - g_dut[0].wtime[b_we % 64]), 32'(k));
    end

    // Read behind a posted write to the same address.
    do_write(8'h20, 8'h5A, s);
    check_eq("wr20_stall", 32'(s), 32'd0);
    do_read(8'h20, d, s, l);
    check_eq("rd20_stall", 32'(s), 32'd4);
    check_eq("rd20_latency", 32'(l), 32'd4);
    check_eq("rd20_data", 32'(d), 32'h5A);
    idle(3);

    // Simultaneous read and write: write wins, error sticks.
    check_eq("err_before", 32'(mem_err_w[0]), 32'd0);
    b_we = g_dut[0].we_cnt;
    b_rv = g_dut[0].rv_cnt;
    mrd = 1'b1;
    do_write(8'h07, 8'h77, s);
    mrd = 1'b0;
    check_eq("err_wr_stall", 32'(s), 32'd0);
    idle(8);
    check_eq("err_we_cycles", 32'(g_dut[0].we_cnt - b_we), 32'd3);
    check_eq("err_ram_write", 32'(g_dut[0].wlog[b_we % 64]), 32'h0777);
    check_eq("err_no_rvalid", 32'(g_dut[0].rv_cnt - b_rv), 32'd0);
    check_eq("err_set", 32'(mem_err_w[0]), 32'd1);
    idle(5);
    check_eq("err_held", 32'(mem_err_w[0]), 32'd1);

    // Reset in the second cycle of a read.
    b_rv = g_dut[0].rv_cnt;
    mrd = 1'b1;
    mem_addr = 8'h10;
    #1;
    check_eq("rstrd_ready", 32'(t_ready), 32'd1);
    @(negedge clk);
    mrd = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rstrd_ce_before", 32'(ram_ce_w[0]), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rstrd_strobes_off", 32'({ram_ce_w[0], ram_oe_w[0], mem_rvalid_w[0]}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstrd_err_cleared", 32'(mem_err_w[0]), 32'd0);
    idle(6);
    check_eq("rstrd_no_rvalid", 32'(g_dut[0].rv_cnt - b_rv), 32'd0);
    do_read(8'h10, d, s, l);
    check_eq("rstrd_next_stall", 32'(s), 32'd0);
    check_eq("rstrd_next_latency", 32'(l), 32'd4);
    check_eq("rstrd_next_data", 32'(d), 32'hA5);
    idle(3);

    // WAIT_STATES=0 instance.
    sel = 1;
    idle(2);
    b_oe = g_dut[1].oe_cnt;
    do_read(8'h10, d, s, l);
    check_eq("ws0_rd_latency", 32'(l), 32'd2);
    check_eq("ws0_rd_data", 32'(d), 32'hA5);
    idle(3);
    check_eq("ws0_oe_cycles", 32'(g_dut[1].oe_cnt - b_oe), 32'd1);
    b_we = g_dut[1].we_cnt;
    do_write(8'h40, 8'h44, s);
    check_eq("ws0_wr_stall", 32'(s), 32'd0);
    do_read(8'h40, d, s, l);
    check_eq("ws0_rd40_stall", 32'(s), 32'd2);
    check_eq("ws0_rd40_latency", 32'(l), 32'd2);
    check_eq("ws0_rd40_data", 32'(d), 32'h44);
    idle(3);
    check_eq("ws0_we_cycles", 32'(g_dut[1].we_cnt - b_we), 32'd1);
    check_eq("ws0_ram_write", 32'(g_dut[1].wlog[b_we % 64]), 32'h4044);

    check_eq("we_oe_overlap_ws2", 32'(g_dut[0].both_cnt), 32'd0);
    check_eq("we_oe_overlap_ws0", 32'(g_dut[1].both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default `MEMORY_SIZE_ENC+1, the memory address width.
REQ-002 SHALL have parameter DATA_W, default `MEMORY_WIDTH, the memory data width.
REQ-003 SHALL have parameter WAIT_STATES, default 2, the extra RAM access cycles, legal range 0..7.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port mem_addr, input, ADDR_W, the request address from Die.
REQ-007 SHALL have port mem_wdata, input, DATA_W, the write data from Die.
REQ-008 SHALL have port mrd, input, 1, the read request, held until accepted.
REQ-009 SHALL have port mwr, input, 1, the write request, held until accepted.
REQ-010 SHALL have port mem_ready, output, 1, request accepted this cycle.
REQ-011 SHALL have port mem_rdata, output, DATA_W, the read data.
REQ-012 SHALL have port mem_rvalid, output, 1, a one-cycle pulse qualifying mem_rdata.
REQ-013 SHALL have port mem_err, output, 1, sticky, set on simultaneous mrd and mwr.
REQ-014 SHALL have ports ram_addr (output, ADDR_W), ram_wdata (output, DATA_W) and ram_rdata (input, DATA_W).
REQ-015 SHALL have ports ram_ce, ram_we and ram_oe, each output, 1, the active-high external SRAM strobes.

Function
REQ-016 SHALL implement a 2-entry posted write buffer of {addr, data}.
REQ-017 SHALL accept a write (mwr && mem_ready) when the buffer is not full, regardless of FSM state except RD_ACCESS/RD_RESP.
REQ-018 SHALL accept a read (mrd && !mwr && mem_ready) only when state==IDLE and the buffer is empty; reads never bypass posted writes.
REQ-019 SHALL drive mem_ready combinationally from current state, buffer count and mrd/mwr, without depending on mem_ready itself.
REQ-020 SHALL use FSM states IDLE, WR_ACCESS, RD_ACCESS and RD_RESP.
REQ-021 SHALL transition IDLE->WR_ACCESS when the buffer is non-empty (drain has priority over a new read).
REQ-022 SHALL transition IDLE->RD_ACCESS on read accept, latching mem_addr.
REQ-023 WR_ACCESS SHALL hold ram_ce=1, ram_we=1 and ram_addr/ram_wdata equal to the buffer head for WAIT_STATES+1 cycles, then pop the head and return to IDLE, or stay in WR_ACCESS for the next entry with no idle cycle when the buffer remains non-empty.
REQ-024 RD_ACCESS SHALL hold ram_ce=1, ram_oe=1 and ram_addr for WAIT_STATES+1 cycles, sample ram_rdata on the last cycle, then go to RD_RESP.
REQ-025 RD_RESP SHALL pulse mem_rvalid=1 for one cycle with the sampled data, then go to IDLE.
REQ-026 Read latency SHALL be exactly WAIT_STATES+2 cycles from the accept edge to the mem_rvalid cycle.
REQ-027 SHALL use a wait counter of 3 bits, loaded with WAIT_STATES on access entry and decremented to 0; the access ends when the counter reads 0.
REQ-028 When full, a push coinciding with a pop SHALL be refused (mem_ready=0); full is evaluated from the pre-pop count.
REQ-029 When mrd and mwr are asserted together, the write SHALL be processed, the read ignored, and mem_err set until reset.
REQ-030 mem_rdata SHALL hold its last value between pulses.
REQ-031 Buffer pointers SHALL be 1 bit and wrap 1->0.
REQ-032 ram_we and ram_oe SHALL never be asserted in the same cycle.

Reset
REQ-033 On rst, asynchronously: state=IDLE, buffer count=0, pointers=0, wait counter=0.
REQ-034 On rst, asynchronously: mem_rvalid=0, mem_err=0, mem_rdata=0, ram_ce/ram_we/ram_oe=0, ram_addr=0, ram_wdata=0.
REQ-035 Reset mid-access SHALL discard the in-flight access and all buffered writes, with no mem_rvalid issued.

Structure
REQ-036 SHALL place the state enum mem_ctrl_state_t and WB_DEPTH=2 in package mem_ctrl_pkg.
REQ-037 SHALL implement the write buffer as sub-module mem_wbuf (push/pop/full/empty/head), with mem_ctrl holding the FSM and counter.

Verification (WAIT_STATES=2)
REQ-038 Single read: mrd, addr 0x10, RAM returns 0xA5 -> mem_rvalid at accept+4, mem_rdata=0xA5, ram_oe high exactly 3 cycles.
REQ-039 Three back-to-back writes (0x1/0x11, 0x2/0x22, 0x3/0x33) -> the first two are accepted immediately and the third is stalled until the first pop; RAM sees three 3-cycle write pulses in order with no gap.
REQ-040 Write 0x20/0x5A then read 0x20 -> the read is stalled until the write drains; the RAM model returns 0x5A.
REQ-041 mrd=mwr=1 at addr 0x7 -> exactly one RAM write, no mem_rvalid, mem_err=1 held.
REQ-042 rst asserted in the 2nd cycle of a read -> ram_ce drops in the same cycle, no mem_rvalid, buffer empty, and the next read completes normally.
REQ-043 WAIT_STATES=0 rebuild: read latency is 2 cycles; each write occupies 1 RAM cycle.
